// File: rtl/awg_shadow_reg_bank.sv
// Double-buffered multi-channel parameter bank: writes land in shadow registers and a
// commit copies every shadow to the active outputs on one edge, optionally aligned to sync.
module awg_shadow_reg_bank #(
    parameter int unsigned      WIDTH     = 12,
    parameter int unsigned      NUM_CH    = 4,
    parameter int unsigned      AW        = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               SYNC_MODE = 1'b1
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    commit,
    input  logic                    abort,
    input  logic                    sync,
    input  logic                    rd_sel,
    input  logic [AW-1:0]           rd_addr,
    output logic [WIDTH-1:0]        rd_data,
    output logic [NUM_CH*WIDTH-1:0] dout,
    output logic [NUM_CH-1:0]       dirty,
    output logic                    pending,
    output logic                    commit_done
);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shadow [NUM_CH];
    logic [WIDTH-1:0] active [NUM_CH];

    logic [NUM_CH-1:0] wr_mask_c;
    logic [WIDTH-1:0]  rd_mux_c;
    logic              xfer_c;

    // Decode the write channel and readback mux; out-of-range addresses match nothing.
    always_comb begin
        wr_mask_c = '0;
        rd_mux_c  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (wr_en && (wr_addr == AW'(k))) begin
                wr_mask_c[k] = 1'b1;
            end
            if (rd_addr == AW'(k)) begin
                rd_mux_c = rd_sel ? shadow[k] : active[k];
            end
        end
    end

    // Transfer happens on the commit edge itself when unsynchronised, else on the armed sync edge.
    assign xfer_c = ((state == IDLE)  && commit && !SYNC_MODE) ||
                    ((state == ARMED) && sync   && !abort);

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state       <= IDLE;
            pending     <= 1'b0;
            commit_done <= 1'b0;
            rd_data     <= '0;
            dirty       <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                shadow[k] <= RESET_VAL;
                active[k] <= RESET_VAL;
            end
        end else begin
            rd_data     <= rd_mux_c;
            commit_done <= xfer_c;

            case (state)
                IDLE: begin
                    if (commit && SYNC_MODE) begin
                        state   <= ARMED;
                        pending <= 1'b1;
                    end
                end
                ARMED: begin
                    if (abort || sync) begin
                        state   <= IDLE;
                        pending <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    pending <= 1'b0;
                end
            endcase

            // A channel written on the transfer edge stays dirty with its new shadow value.
            if (xfer_c) begin
                dirty <= wr_mask_c;
            end else begin
                dirty <= dirty | wr_mask_c;
            end

            for (int k = 0; k < NUM_CH; k++) begin
                if (xfer_c) begin
                    active[k] <= shadow[k];
                end
                if (wr_mask_c[k]) begin
                    shadow[k] <= wr_data;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_dout
        assign dout[g*WIDTH +: WIDTH] = active[g];
    end

endmodule

// File: tb/tb_awg_shadow_reg_bank.sv
// Bench for awg_shadow_reg_bank: a 3-channel synchronised bank and a 4-channel immediate
// bank share stimulus and are compared every cycle against a behavioural model.
module tb_awg_shadow_reg_bank;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [11:0] wr_data;
    logic        commit;
    logic        abort;
    logic        sync;
    logic        rd_sel;
    logic [1:0]  rd_addr;

    logic [11:0] rd_data_a, rd_data_b;
    logic [35:0] dout_a;
    logic [47:0] dout_b;
    logic [2:0]  dirty_a;
    logic [3:0]  dirty_b;
    logic        pending_a, pending_b;
    logic        commit_done_a, commit_done_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clock = ~Clock;

    awg_shadow_reg_bank #(
        .WIDTH(12), .NUM_CH(3), .AW(2), .RESET_VAL(12'h5A5), .SYNC_MODE(1'b1)
    ) dut_a (
        .Clock(Clock), .Reset(Reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .commit(commit), .abort(abort), .sync(sync), .rd_sel(rd_sel), .rd_addr(rd_addr),
        .rd_data(rd_data_a), .dout(dout_a), .dirty(dirty_a), .pending(pending_a),
        .commit_done(commit_done_a)
    );

    awg_shadow_reg_bank #(
        .WIDTH(12), .NUM_CH(4), .AW(2), .RESET_VAL(12'h000), .SYNC_MODE(1'b0)
    ) dut_b (
        .Clock(Clock), .Reset(Reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .commit(commit), .abort(abort), .sync(sync), .rd_sel(rd_sel), .rd_addr(rd_addr),
        .rd_data(rd_data_b), .dout(dout_b), .dirty(dirty_b), .pending(pending_b),
        .commit_done(commit_done_b)
    );

    // Reference model state, index 0 = dut_a, 1 = dut_b.
    logic [11:0] m_shadow [2][4];
    logic [11:0] m_active [2][4];
    logic [3:0]  m_dirty  [2];
    bit          m_armed  [2];
    bit          m_done   [2];
    logic [11:0] m_rd     [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int i);
        int          nch = (i == 0) ? 3 : 4;
        bit          sm  = (i == 0);
        logic [11:0] rv  = (i == 0) ? 12'h5A5 : 12'h000;
        bit          xfer = 1'b0;
        if (!Reset) begin
            for (int k = 0; k < 4; k++) begin
                m_shadow[i][k] = rv;
                m_active[i][k] = rv;
            end
            m_dirty[i] = '0;
            m_armed[i] = 1'b0;
            m_done[i]  = 1'b0;
            m_rd[i]    = '0;
        end else begin
            if (int'(rd_addr) < nch)
                m_rd[i] = rd_sel ? m_shadow[i][rd_addr] : m_active[i][rd_addr];
            else
                m_rd[i] = '0;
            if (!m_armed[i]) begin
                if (commit) begin
                    if (sm) m_armed[i] = 1'b1;
                    else    xfer = 1'b1;
                end
            end else if (abort) begin
                m_armed[i] = 1'b0;
            end else if (sync) begin
                m_armed[i] = 1'b0;
                xfer = 1'b1;
            end
            if (xfer) begin
                for (int k = 0; k < 4; k++) m_active[i][k] = m_shadow[i][k];
                m_dirty[i] = '0;
            end
            if (wr_en && int'(wr_addr) < nch) begin
                m_shadow[i][wr_addr] = wr_data;
                m_dirty[i][wr_addr]  = 1'b1;
            end
            m_done[i] = xfer;
        end
    endtask

    function automatic logic [63:0] exp_dout(input int i);
        logic [63:0] v = '0;
        int nch = (i == 0) ? 3 : 4;
        for (int k = 0; k < nch; k++) v = v | (64'(m_active[i][k]) << (12 * k));
        return v;
    endfunction

    task automatic compare_all();
        check("a.dout",        64'(dout_a),        exp_dout(0));
        check("a.dirty",       64'(dirty_a),       64'(m_dirty[0]));
        check("a.pending",     64'(pending_a),     64'(m_armed[0]));
        check("a.commit_done", 64'(commit_done_a), 64'(m_done[0]));
        check("a.rd_data",     64'(rd_data_a),     64'(m_rd[0]));
        check("b.dout",        64'(dout_b),        exp_dout(1));
        check("b.dirty",       64'(dirty_b),       64'(m_dirty[1]));
        check("b.pending",     64'(pending_b),     64'(m_armed[1]));
        check("b.commit_done", 64'(commit_done_b), 64'(m_done[1]));
        check("b.rd_data",     64'(rd_data_b),     64'(m_rd[1]));
    endtask

    // Inputs are applied at the falling edge; outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge Clock);
        model_step(0);
        model_step(1);
        #1;
        compare_all();
        @(negedge Clock);
    endtask

    task automatic quiet();
        Reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        commit = 1'b0; abort = 1'b0; sync = 1'b0; rd_sel = 1'b0; rd_addr = '0;
    endtask

    task automatic write(input logic [1:0] a, input logic [11:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
    endtask

    initial begin
        quiet();
        // Reset held with writes, commit and sync active
        Reset = 1'b0; write(2'd1, 12'h777); commit = 1'b1; sync = 1'b1;
        tick(); tick();
        check("rst.dout_a",    64'(dout_a),        64'h5A55A55A5);
        check("rst.dirty_a",   64'(dirty_a),       64'h0);
        check("rst.pending_a", 64'(pending_a),     64'h0);
        check("rst.done_a",    64'(commit_done_a), 64'h0);

        // Synchronised commit: sync arrives 5 cycles after commit
        quiet(); write(2'd1, 12'hABC); tick();
        quiet(); commit = 1'b1; tick();
        check("sync.pending0", 64'(pending_a), 64'h1);
        quiet();
        for (int n = 0; n < 4; n++) begin
            tick();
            check("sync.pending",  64'(pending_a),     64'h1);
            check("sync.hold_ch1", 64'(dout_a[23:12]), 64'h5A5);
            check("sync.no_done",  64'(commit_done_a), 64'h0);
        end
        sync = 1'b1; tick();
        check("sync.ch1",     64'(dout_a[23:12]), 64'hABC);
        check("sync.done",    64'(commit_done_a), 64'h1);
        check("sync.pend0",   64'(pending_a),     64'h0);
        check("sync.dirty",   64'(dirty_a),       64'h0);
        quiet(); tick();
        check("sync.done_1cy", 64'(commit_done_a), 64'h0);

        // Collision: sync and write to ch0 on the same edge while armed
        quiet(); write(2'd0, 12'h055); tick();
        quiet(); commit = 1'b1; tick();
        quiet(); sync = 1'b1; write(2'd0, 12'h123); rd_sel = 1'b1; rd_addr = 2'd0; tick();
        check("coll.active0", 64'(dout_a[11:0]), 64'h055);
        check("coll.dirty0",  64'(dirty_a[0]),   64'h1);
        check("coll.rd_pre",  64'(rd_data_a),    64'h055);
        quiet(); rd_sel = 1'b1; rd_addr = 2'd0; tick();
        check("coll.shadow0", 64'(rd_data_a),    64'h123);

        // Immediate commit on dut_b; same commit arms dut_a
        quiet(); write(2'd3, 12'hFFF); tick();
        quiet(); commit = 1'b1; tick();
        check("imm.ch3",     64'(dout_b[47:36]), 64'hFFF);
        check("imm.done",    64'(commit_done_b), 64'h1);
        check("imm.pending", 64'(pending_b),     64'h0);

        // Abort wins over a same-cycle sync on dut_a
        quiet(); abort = 1'b1; sync = 1'b1; tick();
        check("abort.dout",    64'(dout_a),        64'h5A5ABC055);
        check("abort.pending", 64'(pending_a),     64'h0);
        check("abort.done",    64'(commit_done_a), 64'h0);
        check("abort.dirty",   64'(dirty_a),       64'h1);

        // Readback of out-of-range and in-range channels
        quiet(); rd_sel = 1'b1; rd_addr = 2'd3; tick();
        check("rb.oor_a",  64'(rd_data_a), 64'h0);
        check("rb.ch3_b",  64'(rd_data_b), 64'hFFF);
        quiet(); rd_sel = 1'b1; rd_addr = 2'd1; tick();
        check("rb.shadow1", 64'(rd_data_a), 64'hABC);
        check("rb.oor_wr",  64'(dirty_a),   64'h1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            Reset   = ($urandom_range(0, 99) >= 2);
            wr_en   = ($urandom_range(0, 1) == 1);
            wr_addr = 2'($urandom_range(0, 3));
            wr_data = 12'($urandom);
            commit  = ($urandom_range(0, 99) < 15);
            abort   = ($urandom_range(0, 99) < 8);
            sync    = ($urandom_range(0, 99) < 15);
            rd_sel  = ($urandom_range(0, 1) == 1);
            rd_addr = 2'($urandom_range(0, 3));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
